// File: rtl/sys_pkg.sv
// sys_pkg: shared FSM state encoding and PE mode constants for the systolic controller
package sys_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        STREAM,
        DRAIN,
        DONE
    } ctrl_state_t;

    localparam logic CTRL_LOAD    = 1'b1;
    localparam logic CTRL_COMPUTE = 1'b0;

endpackage

// File: rtl/skew_shift.sv
// skew_shift: ROW-deep 1-bit delay chain whose taps form the diagonal feature enables
module skew_shift #(
    parameter int ROW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    input  logic           din,
    output logic [ROW-1:0] taps
);

    logic [ROW:0] shifted;

    assign shifted = {taps, din};

    // Shift one stage per cycle; a cancelled job flushes the whole line at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            taps <= '0;
        else if (clr)
            taps <= '0;
        else
            taps <= shifted[ROW-1:0];
    end

endmodule

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: sequences weight load, skewed feature streaming and drain for a systolic PE vector
module systolic_ctrl
    import sys_pkg::*;
#(
    parameter int ROW   = 4,
    parameter int LEN_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       abort,
    input  logic [LEN_W-1:0]           cfg_len,
    input  logic                       w_valid,
    output logic                       w_ready,
    input  logic                       f_valid,
    output logic                       f_ready,
    output logic                       weight_en,
    output logic                       ctrl,
    output logic [ROW-1:0]             in_en,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(ROW+1)-1:0]   w_cnt,
    output logic [LEN_W-1:0]           f_cnt
);

    localparam int CW = $clog2(ROW+1);

    ctrl_state_t      state, state_nxt;
    logic [LEN_W-1:0] len;
    logic [CW-1:0]    d_cnt;
    logic             w_acc, f_acc, launch, w_last, f_last, d_last;

    assign w_acc  = w_valid & w_ready;
    assign f_acc  = f_valid & f_ready;
    assign launch = (state == IDLE) & start & ~abort;
    assign w_last = w_cnt == CW'(ROW-1);
    assign f_last = f_cnt == len - 1'b1;
    assign d_last = d_cnt == CW'(ROW-1);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; abort overrides every other transition
    always_comb begin
        state_nxt = state;
        if (abort)
            state_nxt = IDLE;
        else
            case (state)
                IDLE:    if (start) state_nxt = (cfg_len != '0) ? LOAD_W : DONE;
                LOAD_W:  if (w_acc && w_last) state_nxt = STREAM;
                STREAM:  if (f_acc && f_last) state_nxt = DRAIN;
                DRAIN:   if (d_last) state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
    end

    // Handshake and status outputs; abort withdraws both readies in the same cycle
    always_comb begin
        w_ready   = (state == LOAD_W) && !abort;
        f_ready   = (state == STREAM) && !abort;
        weight_en = w_valid && w_ready;
        ctrl      = weight_en ? CTRL_LOAD : CTRL_COMPUTE;
        busy      = state != IDLE;
        done      = (state == DONE) && !abort;
    end

    // Job length latch, beat counters and drain timer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len   <= '0;
            w_cnt <= '0;
            f_cnt <= '0;
            d_cnt <= '0;
        end else begin
            if (launch && cfg_len != '0) begin
                len   <= cfg_len;
                w_cnt <= '0;
                f_cnt <= '0;
            end else begin
                if (w_acc)
                    w_cnt <= w_cnt + 1'b1;
                if (f_acc && f_cnt != '1)
                    f_cnt <= f_cnt + 1'b1;
            end
            d_cnt <= (state == DRAIN) ? d_cnt + 1'b1 : '0;
        end
    end

    skew_shift #(.ROW(ROW)) u_skew (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (abort && state != IDLE),
        .din   (f_acc),
        .taps  (in_en)
    );

endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: randomized job-level checking of systolic_ctrl against a timeline model
module tb_systolic_ctrl;

    localparam int ROW   = 4;
    localparam int LEN_W = 8;
    localparam int CW    = $clog2(ROW+1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic             w_valid = 1'b0;
    logic             f_valid = 1'b0;
    logic             w_ready, f_ready, weight_en, ctrl, busy, done;
    logic [ROW-1:0]   in_en;
    logic [CW-1:0]    w_cnt;
    logic [LEN_W-1:0] f_cnt;

    int total = 0;
    int bad   = 0;
    int prev_w = 0;
    int prev_f = 0;
    bit wv [4096];
    bit fv [4096];
    bit fh [4096];

    systolic_ctrl #(.ROW(ROW), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .cfg_len   (cfg_len),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .f_valid   (f_valid),
        .f_ready   (f_ready),
        .weight_en (weight_en),
        .ctrl      (ctrl),
        .in_en     (in_en),
        .busy      (busy),
        .done      (done),
        .w_cnt     (w_cnt),
        .f_cnt     (f_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] outs();
        return 32'({w_ready, f_ready, weight_en, ctrl, busy, done, in_en});
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One job: the timeline (load end, stream end, done cycle) is derived from the
    // valid patterns, then every cycle is checked against range membership.
    // ab_in<0 aborts |ab_in| cycles after load ends; rst_in<0 resets |rst_in| cycles after stream ends.
    task automatic run_job(input int L, input int ab_in, input int rst_in, input int wp, input int fp);
        int c, n, cl, cs, dc, ab, ra, last, wsum, fsum;
        for (int k = 0; k < 4096; k++) begin
            wv[k] = $urandom_range(99) < wp;
            fv[k] = $urandom_range(99) < fp;
            fh[k] = 1'b0;
        end
        cl = 0; cs = 0; dc = 1; c = 0;
        if (L != 0) begin
            n = 0;
            while (n < ROW && c < 2000) begin c++; if (wv[c]) n++; end
            cl = c;
            n = 0;
            while (n < L && c < 4000) begin c++; if (fv[c]) n++; end
            cs = c;
            dc = cs + ROW + 1;
        end
        ab = (ab_in < 0) ? cl - ab_in : ab_in;
        if (ab > dc) ab = 0;
        ra = (rst_in < 0) ? cs - rst_in : rst_in;
        last = (ra > 0) ? ra : ((ab > 0) ? ab + 1 : dc + 1);
        wsum = (L == 0) ? prev_w : 0;
        fsum = (L == 0) ? prev_f : 0;
        start = 1'b1; abort = 1'b0; cfg_len = LEN_W'(L);
        w_valid = 1'($urandom); f_valid = 1'($urandom);
        @(posedge clk); #1;
        for (int cc = 1; cc <= last; cc++) begin
            logic on, live, ld, st, wa, fa;
            logic [ROW-1:0] ein;
            logic [9:0] e;
            on   = (ab == 0) || (cc <= ab);
            live = (ab == 0) || (cc < ab);
            ld = live && cc <= cl;
            st = live && cc > cl && cc <= cs;
            wa = ld && wv[cc];
            fa = st && fv[cc];
            fh[cc] = fa;
            for (int i = 0; i < ROW; i++)
                ein[i] = (on && cc - 1 - i >= 0) ? fh[cc-1-i] : 1'b0;
            e = {ld, st, wa, wa, on && cc <= dc, live && cc == dc, ein};
            w_valid = wv[cc]; f_valid = fv[cc];
            abort   = (cc == ab);
            start   = (on && cc <= dc) ? 1'($urandom) : 1'b0;
            cfg_len = LEN_W'($urandom);
            #1;
            check("outs", outs(), 32'(e));
            check("w_cnt", 32'(w_cnt), wsum);
            check("f_cnt", 32'(f_cnt), fsum);
            wsum += int'(wa);
            fsum += int'(fa);
            if (cc == ra) begin
                rst_n = 1'b0;
                #1;
                check("rst_outs", outs(), 32'd0);
                check("rst_w_cnt", 32'(w_cnt), 32'd0);
                check("rst_f_cnt", 32'(f_cnt), 32'd0);
            end
            @(posedge clk); #1;
        end
        start = 1'b0; abort = 1'b0; w_valid = 1'b0; f_valid = 1'b0;
        if (ra > 0) begin
            check("rst_hold", outs(), 32'd0);
            rst_n = 1'b1;
            prev_w = 0;
            prev_f = 0;
        end else begin
            prev_w = wsum;
            prev_f = fsum;
        end
    endtask

    initial begin
        #2;
        check("reset_outs", outs(), 32'd0);
        check("reset_w_cnt", 32'(w_cnt), 32'd0);
        check("reset_f_cnt", 32'(f_cnt), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_job(3, 0, 0, 100, 100);
        run_job(4, 0, 0, 60, 100);
        run_job(4, 0, 0, 100, 60);
        run_job(0, 0, 0, 100, 100);
        run_job(5, -2, 0, 100, 100);
        run_job(4, 0, 0, 100, 100);
        start = 1'b1; abort = 1'b1; cfg_len = 8'd7;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        check("idle_abort", outs(), 32'd0);
        check("idle_abort_w_cnt", 32'(w_cnt), prev_w);
        check("idle_abort_f_cnt", 32'(f_cnt), prev_f);
        for (int j = 0; j < 12; j++)
            run_job($urandom_range(0, 20), ($urandom_range(3) == 0) ? $urandom_range(1, 30) : 0, 0,
                    $urandom_range(40, 100), $urandom_range(40, 100));
        run_job(255, 0, 0, 90, 90);
        run_job(6, 0, -2, 100, 100);
        run_job(3, 0, 0, 100, 100);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/systolic_ctrl.md
SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 Parameter ROW, default 4: number of PEs in the controlled systolic vector.
REQ-002 Parameter LEN_W, default 8: width of the feature-beat count.
REQ-003 The block SHALL have exactly one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 start  in  1  job request, sampled only in IDLE.
REQ-007 abort  in  1  cancels the current job.
REQ-008 cfg_len  in  LEN_W  number of feature beats for the job, sampled with start.
REQ-009 w_valid / w_ready  in / out  1 each  weight-beat handshake.
REQ-010 f_valid / f_ready  in / out  1 each  feature-beat handshake.
REQ-011 weight_en  out  1  gates the weight input into the PE chain.
REQ-012 ctrl  out  1  PE mode: 1 = weight shift, 0 = compute.
REQ-013 in_en  out  ROW  per-PE feature enables, diagonally skewed.
REQ-014 busy / done  out  1 each  busy = job active; done = one-cycle completion pulse.
REQ-015 w_cnt / f_cnt  out  $clog2(ROW+1) / LEN_W  accepted weight and feature beats in the current job.

Function
REQ-016 The FSM SHALL have the states IDLE, LOAD_W, STREAM, DRAIN and DONE.
REQ-017 In IDLE, start=1 with cfg_len!=0 SHALL latch cfg_len, clear w_cnt and f_cnt, and go to LOAD_W.
REQ-018 In IDLE, start=1 with cfg_len==0 SHALL go to DONE directly.
REQ-019 start SHALL be ignored outside IDLE.
REQ-020 In LOAD_W: w_ready=1; a beat is accepted when w_valid&w_ready; weight_en=ctrl=accepted (combinational); w_cnt increments per beat.
REQ-021 A cycle with no accepted weight beat SHALL leave weight_en=0 and ctrl=0 (no shift).
REQ-022 On the ROW-th accepted weight beat the FSM SHALL go to STREAM.
REQ-023 In STREAM: f_ready=1; a beat is accepted when f_valid&f_ready; f_cnt increments per beat.
REQ-024 Skew: in_en[0] SHALL be the accept signal registered one cycle; in_en[i] SHALL be in_en[i-1] registered one cycle.
REQ-025 A bubble (f_valid=0) SHALL propagate as a zero through the in_en skew line.
REQ-026 On the accepted beat where f_cnt reaches the latched length, the FSM SHALL go to DRAIN.
REQ-027 DRAIN SHALL last exactly ROW cycles with f_ready=0 while the skew line empties, then go to DONE.
REQ-028 DONE SHALL assert done for one cycle with in_en all zero, then return to IDLE.
REQ-029 busy SHALL be 1 in every state except IDLE.
REQ-030 f_cnt SHALL saturate at 2^LEN_W-1; a length of 2^LEN_W-1 SHALL complete correctly.
REQ-031 abort in any non-IDLE state SHALL go to IDLE next cycle: skew line cleared, counters held, no done pulse.
REQ-032 abort has priority over every simultaneous handshake and state transition.
REQ-033 abort in IDLE SHALL have no effect, and SHALL block a simultaneous start.

Reset
REQ-034 While rst_n=0 the block SHALL be in IDLE with every output, counter, latched length and skew register at 0.
REQ-035 Reset mid-job SHALL discard the job without a done pulse.
REQ-036 After reset is released, the first start SHALL be accepted on the first clock edge.

Structure
REQ-037 A shared package sys_pkg SHALL hold the FSM state enum (ctrl_state_t) and the mode constants CTRL_LOAD=1 and CTRL_COMPUTE=0.
REQ-038 The skew line SHALL be one sub-module, skew_shift (a ROW-deep 1-bit delay chain with taps and synchronous clear).
REQ-039 The FSM and the counters SHALL be inline in systolic_ctrl.

Verification
REQ-040 ROW=4, cfg_len=3, w_valid and f_valid held high -> weight_en high 4 cycles, in_en[0] high 3 cycles starting 1 cycle after the first feature accept, in_en[3] trailing by 3 cycles, done 1 cycle after DRAIN.
REQ-041 w_valid pattern 1,0,1,1,0,1 -> weight_en/ctrl mirror it exactly, w_cnt ends at 4, STREAM entered after the 6th cycle.
REQ-042 cfg_len=4, f_valid pattern 1,1,0,1,1 -> in_en[0] registered pattern 1,1,0,1,1 and in_en[3] the same delayed 3 cycles, f_cnt=4.
REQ-043 start with cfg_len=0 -> busy high for 1 cycle, done pulse, no weight_en, no in_en.
REQ-044 abort on the 2nd STREAM beat -> IDLE next cycle, in_en all zero, no done; a new start is then accepted and the job completes normally.
REQ-045 rst_n asserted asynchronously mid-DRAIN -> all outputs 0 immediately, no done after release.
